// File: rtl/req_encoder_8to3.sv
// Request encoder: loads an 8-bit request vector and presents each pending index once.
// Optional ROUND_ROBIN_EN selects a rotating search start instead of fixed priority.
module req_encoder_8to3 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       EN,
  input  logic [7:0] R,
  input  logic       READY,
  output logic [2:0] W,
  output logic       VALID,
  output logic       BUSY,
  output logic [3:0] COUNT
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     state;
  logic [7:0] pend;
  logic [2:0] sel;
  logic [7:0] grant_mask;
  logic [7:0] pend_next;
  logic [3:0] pop;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr;

  // first set bit at or above ptr, wrapping 7->0
  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // later iterations overwrite earlier ones, so the highest set bit wins
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pend[i]) sel = 3'(i);
    end
  end
`endif

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + 4'(pend[i]);
    end
  end

  assign grant_mask = 8'b0000_0001 << sel;
  assign pend_next  = pend & ~grant_mask;

  assign VALID = (state == DRAIN);
  assign BUSY  = (state == DRAIN);
  assign W     = (state == DRAIN) ? sel : '0;
  assign COUNT = (state == DRAIN) ? pop : '0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      pend  <= '0;
`ifdef ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (EN && (R != '0)) begin
            pend  <= R;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (READY) begin
            pend <= pend_next;
`ifdef ROUND_ROBIN_EN
            ptr  <= sel + 3'd1;
`endif
            if (pend_next == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Self-checking bench for req_encoder_8to3: per-cycle model comparison plus directed literals.
module tb_req_encoder_8to3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       EN;
  logic [7:0] R;
  logic       READY;
  logic [2:0] W;
  logic       VALID;
  logic       BUSY;
  logic [3:0] COUNT;

  int checks   = 0;
  int failures = 0;

  req_encoder_8to3 dut (
    .Clock (Clock),
    .Reset (Reset),
    .EN    (EN),
    .R     (R),
    .READY (READY),
    .W     (W),
    .VALID (VALID),
    .BUSY  (BUSY),
    .COUNT (COUNT)
  );

  always #5 Clock = ~Clock;

  // Reference model: pending set, busy flag and rotation pointer.
  bit [7:0] m_pend = 8'h00;
  bit       m_busy = 1'b0;
  int       m_ptr  = 0;
  bit       started = 1'b0;

  function automatic int pick(input bit [7:0] p, input int ptr);
    int r;
    r = 0;
`ifdef ROUND_ROBIN_EN
    for (int k = 7; k >= 0; k--) begin
      if (p[(ptr + k) % 8]) r = (ptr + k) % 8;
    end
`else
    for (int k = 0; k < 8; k++) begin
      if (p[k]) r = k;
    end
`endif
    return r;
  endfunction

  always @(posedge Clock) begin
    int g;
    if (Reset) begin
      m_pend  = 8'h00;
      m_busy  = 1'b0;
      m_ptr   = 0;
      started = 1'b1;
    end else if (!m_busy) begin
      if (EN && R != 8'h00) begin
        m_pend = R;
        m_busy = 1'b1;
      end
    end else if (READY) begin
      g         = pick(m_pend, m_ptr);
      m_pend[g] = 1'b0;
      m_ptr     = (g + 1) % 8;
      if (m_pend == 8'h00) m_busy = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%0b busy=%0b w=%0d count=%0d, want valid=%0b busy=%0b w=%0d count=%0d",
               name, act[9], act[8], act[7:5], act[3:0], exp[9], exp[8], exp[7:5], exp[3:0]);
    end
  endtask

  task automatic lit(input string name, input int w, input bit v, input bit b, input int c);
    chk(name, {VALID, BUSY, W, 1'b0, COUNT}, {v, b, 3'(w), 1'b0, 4'(c)});
  endtask

  always @(negedge Clock) begin
    if (started) begin
      chk("model", {VALID, BUSY, W, 1'b0, COUNT},
          {m_busy, m_busy, (m_busy ? 3'(pick(m_pend, m_ptr)) : 3'd0), 1'b0,
           (m_busy ? 4'($countones(m_pend)) : 4'd0)});
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic load(input logic [7:0] v, input logic rdy);
    EN = 1'b1; R = v; READY = rdy;
    tick();
    EN = 1'b0; R = 8'h00;
  endtask

  initial begin
    bit [7:0] seen;
    bit       dup;
    Reset = 1'b1; EN = 1'b0; R = 8'h00; READY = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    lit("reset_idle", 0, 0, 0, 0);

`ifdef ROUND_ROBIN_EN
    load(8'h11, 1'b1);
    lit("rr_a0", 0, 1, 1, 2); tick();
    lit("rr_a1", 4, 1, 1, 1); tick();
    lit("rr_a_idle", 0, 0, 0, 0);
    load(8'h11, 1'b1);
    lit("rr_b0", 0, 1, 1, 2); tick();
    lit("rr_b1", 4, 1, 1, 1); tick();
    lit("rr_b_idle", 0, 0, 0, 0);
    load(8'h30, 1'b1);
    lit("rr_c0", 5, 1, 1, 2); tick();
    lit("rr_c1", 4, 1, 1, 1); tick();
    lit("rr_c_idle", 0, 0, 0, 0);
`else
    load(8'b1010_0100, 1'b1);
    lit("seq_w7", 7, 1, 1, 3); tick();
    lit("seq_w5", 5, 1, 1, 2); tick();
    lit("seq_w2", 2, 1, 1, 1); tick();
    lit("seq_idle", 0, 0, 0, 0);

    load(8'h81, 1'b0);
    for (int i = 0; i < 3; i++) begin
      lit("stall_hold", 7, 1, 1, 2); tick();
    end
    lit("stall_hold", 7, 1, 1, 2);
    READY = 1'b1; tick();
    lit("stall_w0", 0, 1, 1, 1); tick();
    lit("stall_idle", 0, 0, 0, 0);
`endif

    // EN in DRAIN, including on the final handshake, must be ignored
    load(8'hA4, 1'b0);
    EN = 1'b1; R = 8'hFF; tick();
    EN = 1'b0; R = 8'h00; READY = 1'b1; tick();
    tick();
    EN = 1'b1; R = 8'hFF; tick();
    EN = 1'b0; R = 8'h00;
    lit("en_drain_idle", 0, 0, 0, 0);
    EN = 1'b1; R = 8'h00; tick();
    EN = 1'b0;
    lit("zero_load_idle", 0, 0, 0, 0);

    // reset mid-drain discards in-flight requests
    load(8'hFF, 1'b1);
    tick(); tick();
    Reset = 1'b1; tick();
    Reset = 1'b0;
    lit("rst_mid_drain", 0, 0, 0, 0);
    tick();
    lit("rst_stays_idle", 0, 0, 0, 0);

    // full load: every index exactly once, count 8 down to 1
    seen = 8'h00; dup = 1'b0;
    load(8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      lit("full_count", int'(W), 1, 1, 8 - i);
      if (seen[W]) dup = 1'b1;
      seen[W] = 1'b1;
      tick();
    end
    checks++;
    if (seen != 8'hFF || dup) begin
      failures++;
      $display("FAIL full_distinct: got seen=%h dup=%0b, want seen=ff dup=0", seen, dup);
    end
    lit("full_idle", 0, 0, 0, 0);

    // intermittent READY against the model
    load(8'h5A, 1'b0);
    for (int i = 0; i < 12; i++) begin
      READY = i[0];
      tick();
    end
    READY = 1'b0;
    lit("toggle_idle", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
